// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and register constants for the hazard/stall sequencer
package hazard_pkg;
    typedef enum logic {RUN = 1'b0, BR_STALL = 1'b1} state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with asynchronous active-low clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: per-cycle advance/hold/bubble control for the 5-stage pipeline
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int WAIT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       RsIFID,
    input  logic [4:0]       RtIFID,
    input  logic             branch_id,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic [4:0]       RdIDEX,
    input  logic             RegWriteIDEX,
    input  logic             MemReadIDEX,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             state_o,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t state, nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic freeze, match, loadUse, branchAlu, redirect, stall;

    assign freeze    = mem_req && !mem_ready;
    assign match     = (RdIDEX != REG_ZERO) && (RdIDEX == RsIFID || RdIDEX == RtIFID);
    assign loadUse   = MemReadIDEX && match;
    assign branchAlu = branch_id && RegWriteIDEX && !MemReadIDEX && match;
    assign redirect  = jump_id || (branch_id && branch_taken);
    // a freeze masks every lower-priority hazard, including a pending BR_STALL cycle
    assign stall     = !freeze && (state == BR_STALL || loadUse || branchAlu);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= RUN;
        else state <= nextState;

    always_comb begin
        nextState = freeze ? state :
                    (state == RUN && loadUse && branch_id) ? BR_STALL : RUN;
    end

    always_comb begin
        pc_en       = rst_n && !freeze && !stall;
        ifid_en     = rst_n && !freeze && !stall;
        idex_en     = rst_n && !freeze;
        exmem_en    = rst_n && !freeze;
        ifid_flush  = rst_n && !freeze && !stall && redirect;
        idex_flush  = rst_n && stall;
        memwb_flush = rst_n && freeze;
        state_o     = state;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            waitCnt     <= '0;
            mem_timeout <= 1'b0;
        end else begin
            waitCnt <= !freeze ? '0 : (waitCnt == WAIT_MAX) ? waitCnt : waitCnt + 1'b1;
            if (freeze && waitCnt == WAIT_MAX - 1'b1) mem_timeout <= 1'b1;
        end

    sat_counter #(.W(CNT_W)) uStallCnt (.clk(clk), .rst_n(rst_n), .inc(stall), .q(stall_cnt));
    sat_counter #(.W(CNT_W)) uFlushCnt (.clk(clk), .rst_n(rst_n), .inc(ifid_flush), .q(flush_cnt));
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench with directed vectors for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] RsIFID = '0, RtIFID = '0, RdIDEX = '0;
  logic branch_id = 0, branch_taken = 0, jump_id = 0;
  logic RegWriteIDEX = 0, MemReadIDEX = 0, mem_req = 0, mem_ready = 0;
  logic pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush;
  logic state_o, mem_timeout;
  logic [1:0] stall_cnt, flush_cnt;
  localparam logic [6:0] NORM  = 7'b1111_000;
  localparam logic [6:0] STALL = 7'b0011_010;
  localparam logic [6:0] REDIR = 7'b1111_100;
  localparam logic [6:0] FRZ   = 7'b0000_001;
  localparam logic [6:0] ZERO  = 7'b0000_000;
  hazard_stall_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4), .WAIT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .RsIFID(RsIFID), .RtIFID(RtIFID),
    .branch_id(branch_id), .branch_taken(branch_taken), .jump_id(jump_id),
    .RdIDEX(RdIDEX), .RegWriteIDEX(RegWriteIDEX), .MemReadIDEX(MemReadIDEX),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .memwb_flush(memwb_flush), .state_o(state_o),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  string name_q[$];
  logic [12:0] exp_q[$];
  int checks = 0;
  int fails = 0;
  function automatic logic [12:0] snap();
    return {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush,
            state_o, mem_timeout, stall_cnt, flush_cnt};
  endfunction
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      string nm;
      logic [12:0] e, a;
      nm = name_q.pop_front();
      e = exp_q.pop_front();
      a = snap();
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got ctl=%b st=%b tmo=%b stall=%0d flush=%0d, want ctl=%b st=%b tmo=%b stall=%0d flush=%0d",
                 nm, a[12:6], a[5], a[4], a[3:2], a[1:0], e[12:6], e[5], e[4], e[3:2], e[1:0]);
      end
    end
  end
  task automatic check(input string nm, input logic [12:0] got, input logic [12:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask
  task automatic step(input string nm, input logic rst,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic br, input logic tk, input logic jp, input logic rw,
                      input logic mr, input logic mq, input logic my,
                      input logic [6:0] ctl, input logic st, input logic tmo,
                      input logic [1:0] sc, input logic [1:0] fc);
    @(posedge clk);
    #1;
    rst_n = rst; RsIFID = rs; RtIFID = rt; RdIDEX = rd;
    branch_id = br; branch_taken = tk; jump_id = jp;
    RegWriteIDEX = rw; MemReadIDEX = mr; mem_req = mq; mem_ready = my;
    name_q.push_back(nm);
    exp_q.push_back({ctl, st, tmo, sc, fc});
  endtask
  initial begin
    step("reset",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO,  0, 0, 0, 0);
    step("idle",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0, 0, 0, 0);
    step("load_use",      1, 5, 0, 5, 0, 0, 0, 1, 1, 0, 0, STALL, 0, 0, 0, 0);
    step("after_lu",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0, 0, 1, 0);
    step("br_load_1",     1, 0, 8, 8, 1, 1, 0, 1, 1, 0, 0, STALL, 0, 0, 1, 0);
    step("br_load_2",     1, 0, 8, 0, 1, 1, 0, 0, 0, 0, 0, STALL, 1, 0, 2, 0);
    step("br_resolve",    1, 0, 8, 0, 1, 1, 0, 0, 0, 0, 0, REDIR, 0, 0, 3, 0);
    step("zero_reg",      1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, REDIR, 0, 0, 3, 1);
    step("idle2",         1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0, 0, 3, 2);
    step("stall_sat",     1, 5, 0, 5, 0, 0, 0, 1, 1, 0, 0, STALL, 0, 0, 3, 2);
    step("br_alu",        1, 7, 0, 7, 1, 1, 0, 1, 0, 0, 0, STALL, 0, 0, 3, 2);
    step("after_bralu",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0, 0, 3, 2);
    step("jump_1",        1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, REDIR, 0, 0, 3, 2);
    step("jump_2",        1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, REDIR, 0, 0, 3, 3);
    step("flush_sat",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0, 0, 3, 3);
    step("enter_brst",    1, 0, 8, 8, 1, 0, 0, 1, 1, 0, 0, STALL, 0, 0, 3, 3);
    step("frz_brst_1",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,   1, 0, 3, 3);
    step("frz_brst_2",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,   1, 0, 3, 3);
    step("frz_brst_3",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,   1, 0, 3, 3);
    step("mem_rdy_brst",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, STALL, 1, 0, 3, 3);
    step("run_again",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0, 0, 3, 3);
    step("tmo_frz_1",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,   0, 0, 3, 3);
    step("tmo_frz_2",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,   0, 0, 3, 3);
    step("tmo_frz_3",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,   0, 0, 3, 3);
    step("tmo_frz_4",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,   0, 0, 3, 3);
    step("tmo_frz_5",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,   0, 1, 3, 3);
    step("tmo_frz_6",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,   0, 1, 3, 3);
    step("tmo_rdy",       1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NORM,  0, 1, 3, 3);
    #1 check("tmo_expired", {12'b0, mem_timeout}, 13'd1);
    step("tmo_sticky",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0, 1, 3, 3);
    step("pre_rst_brst",  1, 0, 8, 8, 1, 0, 0, 1, 1, 0, 0, STALL, 0, 1, 3, 3);
    step("async_rst",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO,  0, 0, 0, 0);
    #1 check("async_rst_now", snap(), 13'd0);
    step("rst_hold",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO,  0, 0, 0, 0);
    step("post_rst",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  0, 0, 0, 0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS core; sits beside the forwarding logic.
- Decides every cycle which pipeline registers advance, hold or bubble: load-use stalls, ID-stage branch operand stalls (1 or 2 cycles), branch/jump flushes and data-memory wait freezes.
- Keeps saturating stall/flush statistics and a sticky memory-timeout flag.

Parameters:
- CNT_W, 16, width of the stall and flush statistic counters.
- MEM_TIMEOUT, 64, number of consecutive freeze cycles after which mem_timeout sets.
- WAIT_W, 8, width of the internal freeze-cycle counter; must satisfy 2^WAIT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- RsIFID, RtIFID  input  5  source registers of the instruction in ID.
- branch_id  input  1  ID instruction is a branch or jr that reads its operands in ID.
- branch_taken  input  1  ID branch resolved taken this cycle.
- jump_id  input  1  ID instruction is j or jal.
- RdIDEX  input  5  destination register of the EX instruction.
- RegWriteIDEX, MemReadIDEX  input  1  EX instruction writes a register / is a load.
- mem_req  input  1  MEM-stage data access in progress.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en  output  1  pipeline register write enables.
- ifid_flush, idex_flush, memwb_flush  output  1  bubble insertion; zero the control fields.
- state_o  output  1  0=RUN, 1=BR_STALL.
- mem_timeout  output  1  sticky timeout flag.
- stall_cnt, flush_cnt  output  CNT_W  statistic counters.

Behaviour:
- Reset:
  - While rst_n=0: all enables=0, all flushes=0; state RUN; stall_cnt, flush_cnt, wait counter and mem_timeout cleared asynchronously.
  - Normal operation resumes on the first edge after release.
- Outputs are combinational (Mealy) from state and inputs. The default with no hazard is all enables=1 and all flushes=0.
- Hazard evaluation uses a zero guard: RdIDEX=0 never matches. A "match" is RdIDEX==RsIFID or RdIDEX==RtIFID.
- Priority, highest first:
  1. Freeze (mem_req && !mem_ready):
     - pc_en, ifid_en, idex_en, exmem_en = 0; memwb_flush = 1; every other output at default.
     - State holds and counters (except the wait counter) hold.
     - A pending BR_STALL cycle is preserved, not consumed.
  2. State BR_STALL:
     - pc_en=0, ifid_en=0, idex_flush=1.
     - Next state RUN, unconditionally.
  3. Load-use (MemReadIDEX && match):
     - pc_en=0, ifid_en=0, idex_flush=1 for this cycle.
     - If branch_id also holds, next state = BR_STALL, giving 2 total stall cycles because the branch needs the value in ID.
  4. Branch ALU hazard (branch_id && RegWriteIDEX && !MemReadIDEX && match):
     - Same 1-cycle stall as rule 3.
     - State stays RUN.
  5. Redirect (jump_id, or branch_id && branch_taken):
     - ifid_flush=1; pc_en=1.
     - branch_taken is ignored in any cycle where rules 1-4 apply.
- The cycle mem_ready rises with mem_req high is not a freeze: enables return to 1 in that same cycle.
- stall_cnt: +1 on each cycle where rule 2, 3 or 4 drives pc_en=0. Saturates at all-ones; freeze cycles are not counted.
- flush_cnt: +1 on each cycle with ifid_flush=1. Saturates at all-ones.
- Wait counter:
  - Increments on each freeze cycle and clears on any non-freeze cycle; saturates at MEM_TIMEOUT.
  - When it reaches MEM_TIMEOUT, mem_timeout sets at that edge and stays set until reset.
  - The freeze itself continues regardless.
- Reset asserted mid-stall or mid-freeze: state returns to RUN immediately; no pending stall survives reset.

Decomposition:
- Package hazard_pkg holds the state encoding (RUN=1'b0, BR_STALL=1'b1) and the constant REG_ZERO=5'd0.
- Sub-module sat_counter (parameter W; ports clk, rst_n, inc, q) is used twice for stall_cnt and flush_cnt.
- Everything else lives in the top module.

Test Plan:
- Load-use: MemReadIDEX=1, RdIDEX=5, RsIFID=5, branch_id=0 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, state_o stays 0; stall_cnt 0->1.
- Branch after load: MemReadIDEX=1, RdIDEX=8, RtIFID=8, branch_id=1 -> two consecutive stall cycles, state_o goes 0->1->0; stall_cnt +2; branch_taken during the stall cycles gives ifid_flush=0.
- Zero register: RegWriteIDEX=1, RdIDEX=0, RsIFID=0, branch_id=1 -> no stall; branch_taken=1 gives ifid_flush=1, pc_en=1, flush_cnt +1.
- Freeze inside BR_STALL: enter BR_STALL, then mem_req=1, mem_ready=0 for 3 cycles -> all enables 0 and memwb_flush=1 for 3 cycles with state_o=1 held; after mem_ready=1 one stall cycle remains, then RUN.
- Timeout: MEM_TIMEOUT=4, freeze held 6 cycles -> mem_timeout rises after the 4th freeze edge and stays 1 after mem_ready; clears only when rst_n=0.
- Saturation/reset: CNT_W=2, 5 redirects -> flush_cnt stops at 3; pulse rst_n low mid-stall asynchronously -> all outputs 0, counters 0, state_o=0.
